int_controller: RTL and testbench
=================================

# int_controller

Parametrised interrupt arbiter and issuer for the pcpu core, generalising the single timer/external interrupt path to NSRC sources. Features: per-source level/edge capture, enables, M/S delegation, mode-aware global enables, and fixed-priority arbitration. It holds a registered interrupt request with cause code and target mode until the CPU replies. It pulses a per-source acknowledge when a source is taken, and exports the pending vector for mip/sip readback.

## Interface
- NSRC, 16: number of interrupt sources, 2..32; source index i is the cause code i.
- CODE_W, 5: cause code width, must be ≥ $clog2(NSRC).
- EDGE_MASK, 0: bit i = 1 makes source i edge-captured; bit i = 0 makes it level.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- src  in  NSRC  raw interrupt lines from peripherals and timers.
- enable  in  NSRC  per-source enable (mie).
- deleg  in  NSRC  per-source delegation (mideleg); 1 = target S-mode.
- mode  in  2  current privilege: 11 = M, 01 = S, 00 = U.
- gie_m  in  1  mstatus.MIE.
- gie_s  in  1  mstatus.SIE.
- int_reply  in  1  CPU has entered the trap; level, held until interrupt drops.
- interrupt  out  1  request to CPU; held high until reply.
- int_cause  out  CODE_W  index of the issued source; valid while interrupt = 1.
- int_to_s  out  1  1 = trap to S-mode; 0 = trap to M-mode. Valid with interrupt.
- src_ack  out  NSRC  one-cycle pulse on the bit of the issued source.
- pending  out  NSRC  registered pending vector for mip readback.

## Operation
- Input stage: src, enable, deleg, mode, gie_m, gie_s and int_reply are registered once (*_q). All decisions use only the registered copies.
- Pending bits:
  - Edge source i: pend[i] sets when src_q[i] & ~src_qq[i]. It clears when src_ack[i] is issued. If set and clear happen in the same cycle, set wins.
  - Level source i: pend[i] = src_q[i]. The device must drop src after src_ack.
- The pending output equals pend.
- Takeable, source i with pend & enable_q:
  - deleg_q[i] = 0 (M-target): taken when mode_q != 11, or when mode_q = 11 and gie_m_q.
  - deleg_q[i] = 1 (S-target): taken when mode_q = 00, or when mode_q = 01 and gie_s_q. Never taken in M-mode.
- Arbitration:
  - The highest-index takeable M-target wins.
  - If there is none, the highest-index takeable S-target wins.
  - The decision is frozen when latched in IDLE.
- State machine (2-bit):
  - IDLE: if any takeable source, latch win_idx and win_s, then go to ISSUE.
  - ISSUE: interrupt <= 1, int_cause <= win_idx, int_to_s <= win_s, src_ack[win_idx] <= 1. Go to WAIT.
  - WAIT: src_ack <= 0. When int_reply_q = 1, interrupt <= 0 and go to END.
  - END: go to IDLE. This is one dead cycle so that the CPU's mstatus update propagates through the input stage before the next arbitration.
- Enable, deleg or mode changes after the IDLE latch do not retract or alter an issued request.
- Width rule: int_cause = win_idx zero-extended to CODE_W.

## Timing
- Reset values:
  - interrupt = 0, int_cause = 0, int_to_s = 0, src_ack = 0, pending = 0.
  - state = IDLE; all *_q registers are 0.
- rst asserted in any state returns to IDLE on the next edge. Any in-flight request and any captured edge pend bits are dropped.
- Latency, counted in edges, with src rising before edge 1 and all enables set:
  - edge 1: src_q.
  - edge 2: pend/IDLE→ISSUE.
  - edge 3: interrupt = 1, src_ack pulse.
- Edge sources add one edge (pend is registered), so interrupt rises at edge 4.
- Reply latency: int_reply high before edge k gives int_reply_q at edge k, and interrupt = 0 at edge k+1.
- The next issue can occur no earlier than 3 edges after interrupt falls (END, IDLE, ISSUE).
- A reply asserted during ISSUE or IDLE is ignored; only the WAIT state samples it.
- Pulses shorter than one clock on an edge source may be missed; source pulses must be ≥ 1 cycle wide.

## Test plan
- Level source 7, M-target, mode = 11, gie_m = 1, enable[7] = 1, src[7] rises at edge 0 → interrupt = 1 and int_cause = 7 at edge 3. src_ack[7] is high for exactly one cycle. The request is held until int_reply; interrupt = 0 two edges after reply.
- Sources 3 and 11 both pending, M-targets → cause 11 issued first. After reply, and with src[11] dropped, cause 3 is issued.
- deleg[9] = 1, mode = 11 → source 9 is never issued. Switch mode to 01 with gie_s = 1 → cause 9 issued with int_to_s = 1. Mode 01 with M-target 5 also pending → 5 wins with int_to_s = 0.
- Edge source 2 (EDGE_MASK bit 2 = 1) gets a one-cycle pulse while gie_m = 0 → pending[2] stays 1. Setting gie_m later → issued. A second rising edge in the same cycle as src_ack[2] → pending[2] remains 1 and the source is issued again.
- Assert rst while in WAIT with interrupt = 1 → after one edge all outputs and pending read 0 and state is IDLE. With src still high after reset, the source is re-issued at the normal latency.

Source files
------------

// File: rtl/int_controller.sv
// Interrupt arbiter/issuer: captures NSRC sources, applies enables, delegation and
// mode-aware global enables, and holds one registered request until the CPU replies.
module int_controller #(
    parameter int unsigned     NSRC      = 16,
    parameter int unsigned     CODE_W    = 5,
    parameter logic [NSRC-1:0] EDGE_MASK = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   src,
    input  logic [NSRC-1:0]   enable,
    input  logic [NSRC-1:0]   deleg,
    input  logic [1:0]        mode,
    input  logic              gie_m,
    input  logic              gie_s,
    input  logic              int_reply,
    output logic              interrupt,
    output logic [CODE_W-1:0] int_cause,
    output logic              int_to_s,
    output logic [NSRC-1:0]   src_ack,
    output logic [NSRC-1:0]   pending
);

    localparam int unsigned IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_END   = 2'd3
    } state_t;

    logic [NSRC-1:0]   src_q, src_qq, enable_q, deleg_q;
    logic [1:0]        mode_q;
    logic              gie_m_q, gie_s_q, reply_q;
    logic [NSRC-1:0]   edge_pend_q, edge_pend_d;
    logic [NSRC-1:0]   pend;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  win_idx_q, win_idx_d;
    logic              win_s_q, win_s_d;
    logic              interrupt_q, interrupt_d;
    logic [CODE_W-1:0] cause_q, cause_d;
    logic              to_s_q, to_s_d;
    logic [NSRC-1:0]   ack_q, ack_d;

    logic              m_ok, s_ok, m_any, s_any;
    logic [NSRC-1:0]   m_take, s_take;
    logic [IDX_W-1:0]  m_idx, s_idx;

    // Input stage: every decision works from these registered copies only.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q    <= '0;
            src_qq   <= '0;
            enable_q <= '0;
            deleg_q  <= '0;
            mode_q   <= '0;
            gie_m_q  <= 1'b0;
            gie_s_q  <= 1'b0;
            reply_q  <= 1'b0;
        end else begin
            src_q    <= src;
            src_qq   <= src_q;
            enable_q <= enable;
            deleg_q  <= deleg;
            mode_q   <= mode;
            gie_m_q  <= gie_m;
            gie_s_q  <= gie_s;
            reply_q  <= int_reply;
        end
    end

    // Edge capture: a new rising edge beats the clear from the ack pulse.
    assign edge_pend_d = (EDGE_MASK & src_q & ~src_qq) | (edge_pend_q & ~ack_q);
    assign pend        = (EDGE_MASK & edge_pend_q) | (~EDGE_MASK & src_q);

    always_ff @(posedge clk) begin
        if (rst) edge_pend_q <= '0;
        else     edge_pend_q <= edge_pend_d & EDGE_MASK;
    end

    assign m_ok   = (mode_q != 2'b11) || gie_m_q;
    assign s_ok   = (mode_q == 2'b00) || ((mode_q == 2'b01) && gie_s_q);
    assign m_take = pend & enable_q & ~deleg_q & {NSRC{m_ok}};
    assign s_take = pend & enable_q &  deleg_q & {NSRC{s_ok}};

    // Fixed priority: highest index wins within each target class.
    always_comb begin
        m_idx = '0;
        s_idx = '0;
        m_any = 1'b0;
        s_any = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (m_take[i]) begin
                m_idx = IDX_W'(i);
                m_any = 1'b1;
            end
            if (s_take[i]) begin
                s_idx = IDX_W'(i);
                s_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            win_idx_q   <= '0;
            win_s_q     <= 1'b0;
            interrupt_q <= 1'b0;
            cause_q     <= '0;
            to_s_q      <= 1'b0;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            win_idx_q   <= win_idx_d;
            win_s_q     <= win_s_d;
            interrupt_q <= interrupt_d;
            cause_q     <= cause_d;
            to_s_q      <= to_s_d;
            ack_q       <= ack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        win_idx_d   = win_idx_q;
        win_s_d     = win_s_q;
        interrupt_d = interrupt_q;
        cause_d     = cause_q;
        to_s_d      = to_s_q;
        ack_d       = '0;
        unique case (state_q)
            S_IDLE: begin
                if (m_any || s_any) begin
                    win_idx_d = m_any ? m_idx : s_idx;
                    win_s_d   = ~m_any;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                interrupt_d = 1'b1;
                cause_d     = CODE_W'(win_idx_q);
                to_s_d      = win_s_q;
                ack_d       = NSRC'(1) << win_idx_q;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (reply_q) begin
                    interrupt_d = 1'b0;
                    state_d     = S_END;
                end
            end
            // One dead cycle lets the CPU's mstatus write reach the input stage.
            S_END: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign interrupt = interrupt_q;
    assign int_cause = cause_q;
    assign int_to_s  = to_s_q;
    assign src_ack   = ack_q;
    assign pending   = pend;

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed stimulus, expected issues queued and popped by a monitor.
module tb_int_controller;

    localparam int unsigned NSRC   = 16;
    localparam int unsigned CODE_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NSRC-1:0]   src, enable, deleg;
    logic [1:0]        mode;
    logic              gie_m, gie_s, int_reply;
    logic              interrupt;
    logic [CODE_W-1:0] int_cause;
    logic              int_to_s;
    logic [NSRC-1:0]   src_ack, pending;

    int_controller #(
        .NSRC     (NSRC),
        .CODE_W   (CODE_W),
        .EDGE_MASK(16'h0004)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .src      (src),
        .enable   (enable),
        .deleg    (deleg),
        .mode     (mode),
        .gie_m    (gie_m),
        .gie_s    (gie_s),
        .int_reply(int_reply),
        .interrupt(interrupt),
        .int_cause(int_cause),
        .int_to_s (int_to_s),
        .src_ack  (src_ack),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CODE_W-1:0] cause;
        logic              to_s;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            mon_e;
    int              errors = 0;
    int              checks = 0;
    int              issue_cnt = 0;
    logic [NSRC-1:0] prev_ack = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int cause, input bit to_s);
        exp_t e;
        e.cause = CODE_W'(cause);
        e.to_s  = to_s;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the monitor to see one more issue.
    task automatic wait_issue();
        int start;
        start = issue_cnt;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (issue_cnt != start) break;
        end
        chk("issue_seen", 32'(issue_cnt != start), 32'd1);
    endtask

    // CPU reply: request holds through edge k, drops at edge k+1.
    task automatic do_reply();
        int_reply = 1'b1;
        tick();
        chk("hold_until_reply", 32'(interrupt), 32'd1);
        tick();
        chk("drop_after_reply", 32'(interrupt), 32'd0);
        int_reply = 1'b0;
    endtask

    // Monitor: every ack pulse is an issue; compare it against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && src_ack != '0) begin
            issue_cnt++;
            chk("ack_one_cycle", 32'(prev_ack), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got cause %0d expected none", int_cause);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_interrupt", 32'(interrupt), 32'd1);
                chk("sb_cause", 32'(int_cause), 32'(mon_e.cause));
                chk("sb_to_s", 32'(int_to_s), 32'(mon_e.to_s));
                chk("sb_ack_bit", 32'(src_ack), 32'(NSRC'(1) << mon_e.cause));
            end
        end
        prev_ack <= src_ack;
    end

    initial begin
        int start;
        rst = 1'b1; src = '0; enable = '0; deleg = '0; mode = 2'b00;
        gie_m = 1'b0; gie_s = 1'b0; int_reply = 1'b0;
        tick();
        tick();
        chk("rst_interrupt", 32'(interrupt), 32'd0);
        chk("rst_cause", 32'(int_cause), 32'd0);
        chk("rst_to_s", 32'(int_to_s), 32'd0);
        chk("rst_ack", 32'(src_ack), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        rst = 1'b0;

        // Level source 7, M-target, latency and hold.
        enable = 16'h0080; mode = 2'b11; gie_m = 1'b1;
        repeat (3) tick();
        push(7, 1'b0);
        src[7] = 1'b1;
        tick();
        chk("lat_e1", 32'(interrupt), 32'd0);
        tick();
        chk("lat_e2", 32'(interrupt), 32'd0);
        tick();
        chk("lat_e3_int", 32'(interrupt), 32'd1);
        chk("lat_e3_cause", 32'(int_cause), 32'd7);
        chk("lat_e3_ack", 32'(src_ack), 32'h0080);
        src[7] = 1'b0;
        tick();
        chk("ack_cleared", 32'(src_ack), 32'd0);
        repeat (4) tick();
        chk("held", 32'(interrupt), 32'd1);
        do_reply();
        repeat (3) tick();
        chk("pend7_clear", 32'(pending), 32'd0);

        // Sources 3 and 11 together: higher index first.
        enable = 16'h0888;
        push(11, 1'b0);
        push(3, 1'b0);
        src[3] = 1'b1; src[11] = 1'b1;
        wait_issue();
        src[11] = 1'b0;
        do_reply();
        wait_issue();
        src[3] = 1'b0;
        do_reply();
        repeat (3) tick();

        // Delegated source 9 blocked in M-mode, taken in S-mode.
        enable = 16'h0200; deleg = 16'h0200; mode = 2'b11;
        src[9] = 1'b1;
        start = issue_cnt;
        repeat (10) tick();
        chk("s_blocked_in_m", 32'(issue_cnt), 32'(start));
        chk("pend9", 32'(pending), 32'h0200);
        push(9, 1'b1);
        mode = 2'b01; gie_s = 1'b1;
        wait_issue();
        src[9] = 1'b0;
        do_reply();
        repeat (3) tick();
        enable = 16'h0220;
        push(5, 1'b0);
        push(9, 1'b1);
        src[5] = 1'b1; src[9] = 1'b1;
        wait_issue();
        src[5] = 1'b0;
        do_reply();
        wait_issue();
        src[9] = 1'b0;
        do_reply();
        repeat (3) tick();

        // Edge source 2: captured while masked, then set-wins against the ack clear.
        deleg = '0; mode = 2'b11; gie_m = 1'b0; gie_s = 1'b0; enable = 16'h0004;
        repeat (3) tick();
        start = issue_cnt;
        src[2] = 1'b1;
        tick();
        src[2] = 1'b0;
        repeat (6) tick();
        chk("edge_pend_held", 32'(pending), 32'h0004);
        chk("edge_masked", 32'(issue_cnt), 32'(start));
        push(2, 1'b0);
        push(2, 1'b0);
        gie_m = 1'b1;
        tick();
        tick();
        src[2] = 1'b1;
        tick();
        chk("edge_ack", 32'(src_ack), 32'h0004);
        src[2] = 1'b0;
        tick();
        chk("edge_set_wins", 32'(pending), 32'h0004);
        do_reply();
        wait_issue();
        do_reply();
        repeat (3) tick();
        chk("edge_pend_clear", 32'(pending), 32'd0);

        // Reset while waiting for reply, then normal re-issue.
        enable = 16'h0080;
        push(7, 1'b0);
        src[7] = 1'b1;
        wait_issue();
        chk("pre_rst_int", 32'(interrupt), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_interrupt", 32'(interrupt), 32'd0);
        chk("mid_rst_cause", 32'(int_cause), 32'd0);
        chk("mid_rst_to_s", 32'(int_to_s), 32'd0);
        chk("mid_rst_ack", 32'(src_ack), 32'd0);
        chk("mid_rst_pending", 32'(pending), 32'd0);
        rst = 1'b0;
        push(7, 1'b0);
        tick();
        tick();
        chk("rerun_e2", 32'(interrupt), 32'd0);
        tick();
        chk("rerun_e3_int", 32'(interrupt), 32'd1);
        chk("rerun_e3_cause", 32'(int_cause), 32'd7);
        src[7] = 1'b0;
        do_reply();
        repeat (4) tick();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
